// File: rtl/dsp_result_serializer.sv
// Buffers 4-lane DSP result frames in a frame FIFO and streams them out one word per valid/ready transfer.
// Optional build macro SERIALIZER_SAT16_EN saturates each lane to signed 16 bits when the holding register loads.
module dsp_result_serializer #(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   in_result_0,
  input  logic [31:0]   in_result_1,
  input  logic [31:0]   in_result_2,
  input  logic [31:0]   in_result_3,
  input  logic          in_valid,
  input  logic          in_overflow,
  output logic [31:0]   out_data,
  output logic [1:0]    out_chan,
  output logic          out_last,
  output logic          out_ovf,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          frame_drop,
  output logic [7:0]    drop_count,
  output logic [LW-1:0] fifo_level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  logic [128:0]      mem_q [DEPTH];
  logic [PW-1:0]     wrPtr_q, rdPtr_q;
  logic [LW-1:0]     level_q, level_d;
  state_t            state_q, state_d;
  logic [3:0][31:0]  hold_q, hold_d;
  logic [31:0]       outData_q, outData_d;
  logic [1:0]        outChan_q, outChan_d;
  logic              outLast_q, outLast_d;
  logic              outOvf_q, outOvf_d;
  logic              outValid_q, outValid_d;
  logic              frameDrop_q;
  logic [7:0]        dropCount_q;

  logic [128:0]      head;
  logic [3:0][31:0]  loadLanes;
  logic              loadOvf;
  logic              pop, push, drop;
  logic [1:0]        nextChan;

`ifdef SERIALIZER_SAT16_EN
  function automatic logic [31:0] sat16(input logic [31:0] v);
    if ($signed(v) > 32'sd32767)
      return 32'h0000_7FFF;
    else if ($signed(v) < -32'sd32768)
      return 32'hFFFF_8000;
    else
      return v;
  endfunction
`endif

  // Head-of-FIFO frame as it will appear once loaded into the holding register.
  always_comb begin
    head      = mem_q[rdPtr_q];
    loadLanes = head[127:0];
    loadOvf   = head[128];
`ifdef SERIALIZER_SAT16_EN
    for (int i = 0; i < 4; i++) begin
      loadLanes[i] = sat16(head[32*i +: 32]);
      if (loadLanes[i] != head[32*i +: 32])
        loadOvf = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    outData_d  = outData_q;
    outChan_d  = outChan_q;
    outLast_d  = outLast_q;
    outOvf_d   = outOvf_q;
    outValid_d = outValid_q;
    pop        = 1'b0;
    nextChan   = outChan_q + 2'd1;
    case (state_q)
      IDLE: begin
        outValid_d = 1'b0;
        if (level_q != '0) begin
          pop = 1'b1;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (outChan_q != 2'd3) begin
            outChan_d = nextChan;
            outData_d = hold_q[nextChan];
            outLast_d = (nextChan == 2'd3);
          end else if (level_q != '0) begin
            pop = 1'b1;
          end else begin
            outValid_d = 1'b0;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Both load paths (from IDLE and back-to-back) share this reload.
    if (pop) begin
      hold_d     = loadLanes;
      outData_d  = loadLanes[0];
      outChan_d  = 2'd0;
      outLast_d  = 1'b0;
      outOvf_d   = loadOvf;
      outValid_d = 1'b1;
      state_d    = SEND;
    end
  end

  always_comb begin
    push    = in_valid && ((level_q != FULL) || pop);
    drop    = in_valid && !push;
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push && !rst)
      mem_q[wrPtr_q] <= {in_overflow, in_result_3, in_result_2, in_result_1, in_result_0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      level_q     <= '0;
      hold_q      <= '0;
      outData_q   <= '0;
      outChan_q   <= '0;
      outLast_q   <= 1'b0;
      outOvf_q    <= 1'b0;
      outValid_q  <= 1'b0;
      frameDrop_q <= 1'b0;
      dropCount_q <= '0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      hold_q      <= hold_d;
      outData_q   <= outData_d;
      outChan_q   <= outChan_d;
      outLast_q   <= outLast_d;
      outOvf_q    <= outOvf_d;
      outValid_q  <= outValid_d;
      frameDrop_q <= drop;
      if (push)
        wrPtr_q <= wrPtr_q + PW'(1);
      if (pop)
        rdPtr_q <= rdPtr_q + PW'(1);
      if (drop && dropCount_q != 8'hFF)
        dropCount_q <= dropCount_q + 8'd1;
    end
  end

  assign out_data   = outData_q;
  assign out_chan   = outChan_q;
  assign out_last   = outLast_q;
  assign out_ovf    = outOvf_q;
  assign out_valid  = outValid_q;
  assign frame_drop = frameDrop_q;
  assign drop_count = dropCount_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_dsp_result_serializer.sv
// Self-checking bench for dsp_result_serializer: frame-level reference model checked every cycle plus hand-computed expectations.
module tb_dsp_result_serializer;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   r0 = '0, r1 = '0, r2 = '0, r3 = '0;
  logic          in_valid = 1'b0;
  logic          in_overflow = 1'b0;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic [1:0]    out_chan;
  logic          out_last, out_ovf, out_valid, frame_drop;
  logic [7:0]    drop_count;
  logic [LW-1:0] fifo_level;

  dsp_result_serializer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_result_0(r0), .in_result_1(r1), .in_result_2(r2), .in_result_3(r3),
    .in_valid(in_valid), .in_overflow(in_overflow),
    .out_data(out_data), .out_chan(out_chan), .out_last(out_last), .out_ovf(out_ovf),
    .out_valid(out_valid), .out_ready(out_ready),
    .frame_drop(frame_drop), .drop_count(drop_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference model: frames waiting in the buffer, the frame being sent, and drop bookkeeping.
  typedef struct packed {
    logic [3:0][31:0] lane;
    logic             ovf;
  } frame_t;

  frame_t fifoQ[$];
  frame_t holder;
  bit     busy = 0;
  int     idx = 0;
  int     dropCnt = 0;
  bit     dropPulse = 0;
  bit     modelReady = 0;

  function automatic logic [31:0] expWord(input logic [31:0] v);
`ifdef SERIALIZER_SAT16_EN
    longint s;
    s = longint'($signed(v));
    if (s > 32767) return 32'h0000_7FFF;
    if (s < -32768) return 32'hFFFF_8000;
`endif
    return v;
  endfunction

  function automatic logic expOvf(input frame_t f);
    logic o;
    o = f.ovf;
    for (int i = 0; i < 4; i++)
      if (expWord(f.lane[i]) != f.lane[i]) o = 1'b1;
    return o;
  endfunction

  // Compare the DUT with the model, then advance the model by the coming edge's inputs.
  always @(negedge clk) begin
    bit     hs, popNow, accept;
    frame_t inF;
    if (modelReady) begin
      checkOutput("out_valid", 32'(out_valid), 32'(busy));
      checkOutput("fifo_level", 32'(fifo_level), 32'(fifoQ.size()));
      checkOutput("drop_count", 32'(drop_count), 32'(dropCnt));
      checkOutput("frame_drop", 32'(frame_drop), 32'(dropPulse));
      if (busy) begin
        checkOutput("out_data", out_data, expWord(holder.lane[idx]));
        checkOutput("out_chan", 32'(out_chan), 32'(idx));
        checkOutput("out_last", 32'(out_last), 32'(idx == 3));
        checkOutput("out_ovf", 32'(out_ovf), 32'(expOvf(holder)));
      end
    end
    if (rst) begin
      fifoQ.delete();
      busy = 0; idx = 0; dropCnt = 0; dropPulse = 0;
      modelReady = 1;
    end else begin
      hs     = busy && out_ready;
      popNow = (fifoQ.size() > 0) && (!busy || (hs && idx == 3));
      accept = in_valid && (fifoQ.size() < DEPTH || popNow);
      if (hs) begin
        if (idx == 3) busy = 0;
        else idx++;
      end
      if (popNow) begin
        holder = fifoQ.pop_front();
        busy = 1; idx = 0;
      end
      if (accept) begin
        inF.lane = {r3, r2, r1, r0};
        inF.ovf  = in_overflow;
        fifoQ.push_back(inF);
      end
      dropPulse = in_valid && !accept;
      if (dropPulse && dropCnt < 255) dropCnt++;
    end
  end

  task automatic applyStimulus(input logic [31:0] a, b, c, d, input logic ovf);
    @(posedge clk); #1;
    r0 = a; r1 = b; r2 = c; r3 = d; in_overflow = ovf; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitChan(input int c, input string name);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1 && out_chan == 2'(c)) return;
    end
    timeoutFail(name);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (fifoQ.size() == 0 && !busy) return;
    end
    timeoutFail(name);
  endtask

  initial begin
    logic [31:0] expD [4];
    expD[0] = 32'd10; expD[1] = 32'hFFFF_FFEC; expD[2] = 32'd30; expD[3] = 32'hFFFF_FFD8;

    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset fifo_level", 32'(fifo_level), 32'd0);
    checkOutput("reset drop_count", 32'(drop_count), 32'd0);
    checkOutput("reset out_data", out_data, 32'd0);

    // Single frame, consumer always ready: two-cycle latency, then one word per cycle.
    out_ready = 1'b1;
    applyStimulus(32'd10, 32'hFFFF_FFEC, 32'd30, 32'hFFFF_FFD8, 1'b0);
    checkOutput("latency idle", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput("single valid", 32'(out_valid), 32'd1);
      checkOutput("single data", out_data, expD[i]);
      checkOutput("single chan", 32'(out_chan), 32'(i));
      checkOutput("single last", 32'(out_last), 32'(i == 3));
    end
    @(posedge clk); #1;
    checkOutput("single end", 32'(out_valid), 32'd0);

    // Backpressure: first word must hold for three stalled cycles.
    out_ready = 1'b0;
    applyStimulus(32'd10, 32'hFFFF_FFEC, 32'd30, 32'hFFFF_FFD8, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("stall data", out_data, 32'd10);
      checkOutput("stall chan", 32'(out_chan), 32'd0);
    end
    out_ready = 1'b1;
    drain("backpressure drain");

    // Overrun: one frame held, DEPTH buffered, the last one dropped.
    out_ready = 1'b0;
    for (int f = 0; f < DEPTH + 2; f++)
      applyStimulus(32'(100 + f), 32'(200 + f), 32'(300 + f), 32'(400 + f), f[0]);
    @(posedge clk); #1;
    checkOutput("overrun drop_count", 32'(drop_count), 32'd1);
    checkOutput("overrun fifo_level", 32'(fifo_level), 32'(DEPTH));
    out_ready = 1'b1;
    drain("overrun drain");

    // Full buffer with a push coinciding with the last-word handshake.
    out_ready = 1'b0;
    for (int f = 0; f < DEPTH + 1; f++)
      applyStimulus(32'(500 + f), 32'(600 + f), 32'(700 + f), 32'(800 + f), 1'b0);
    @(posedge clk); #1;
    checkOutput("full level", 32'(fifo_level), 32'(DEPTH));
    out_ready = 1'b1;
    waitChan(3, "full last word");
    r0 = 32'd1; r1 = 32'd2; r2 = 32'd3; r3 = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("full+pop drop", 32'(frame_drop), 32'd0);
    checkOutput("full+pop level", 32'(fifo_level), 32'(DEPTH));
    checkOutput("full+pop count", 32'(drop_count), 32'd1);
    drain("full+pop drain");

`ifdef SERIALIZER_SAT16_EN
    applyStimulus(32'h0001_0000, 32'hFFFE_EE90, 32'd5, 32'd0, 1'b0);
    waitChan(0, "sat first word");
    checkOutput("sat pos data", out_data, 32'h0000_7FFF);
    checkOutput("sat ovf", 32'(out_ovf), 32'd1);
    @(posedge clk); #1;
    checkOutput("sat neg data", out_data, 32'hFFFF_8000);
    drain("sat drain");
`endif

    // Reset in the middle of a frame; an in_valid during reset is ignored.
    applyStimulus(32'd7, 32'd8, 32'd9, 32'd11, 1'b0);
    waitChan(2, "reset mid-frame");
    rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    checkOutput("mid reset valid", 32'(out_valid), 32'd0);
    checkOutput("mid reset level", 32'(fifo_level), 32'd0);
    checkOutput("mid reset drops", 32'(drop_count), 32'd0);
    applyStimulus(32'd21, 32'd22, 32'd23, 32'd24, 1'b0);
    waitChan(0, "post reset frame");
    checkOutput("post reset data", out_data, 32'd21);
    drain("final drain");

    repeat (2) begin @(posedge clk); #1; end
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
